// File: rtl/mackerel_bus_pkg.sv
// Shared definitions for the Mackerel bus cycle timer: FSM states, default
// wait-state/timeout constants and counter sizing helpers.
package mackerel_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PERIPH,
    ACK,
    ERR
  } bus_state_t;

  localparam int DEF_ROM_WAIT = 2;
  localparam int DEF_RAM_WAIT = 0;
  localparam int DEF_TIMEOUT  = 255;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold max_val, but never narrower than min_width.
  function automatic int count_width(input int max_val, input int min_width);
    int w;
    w = $clog2(max_val + 1);
    return (w > min_width) ? w : min_width;
  endfunction

endpackage

// File: rtl/mackerel_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a
// parameterized value forced into both stages during reset.
module mackerel_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/mackerel_bus_timer.sv
// Bus cycle timer: acknowledges ROM/SRAM cycles after fixed wait states,
// passes through peripheral acknowledges, and raises BERR on a silent bus.
module mackerel_bus_timer
  import mackerel_bus_pkg::*;
#(
  parameter int ROM_WAIT = DEF_ROM_WAIT,
  parameter int RAM_WAIT = DEF_RAM_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       ROMEN,
  input  logic [3:0] RAMEN,
  input  logic       DTACK_PERIPH,
  output logic       DTACK,
  output logic       BERR,
  output logic       BUSY
);

  localparam int WAIT_W = count_width(max_int(ROM_WAIT, RAM_WAIT), 1);
  localparam int TO_W   = count_width(TIMEOUT, 8);

  localparam logic [WAIT_W-1:0] ROM_LOAD = WAIT_W'(ROM_WAIT);
  localparam logic [WAIT_W-1:0] RAM_LOAD = WAIT_W'(RAM_WAIT);
  localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT);

  bus_state_t        state_q;
  bus_state_t        state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_inc;
  logic              ack_sync;
  logic              rom_sel;
  logic              ram_sel;
  logic              dtack_d;
  logic              berr_d;

  mackerel_sync2 #(
    .RESET_VAL(1'b1)
  ) u_ack_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_in (DTACK_PERIPH),
    .sync_out (ack_sync)
  );

  assign rom_sel = !ROMEN;
  assign ram_sel = (RAMEN != 4'hF);

  // The timeout counter sticks at all-ones instead of wrapping back to zero.
  assign to_cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An address strobe release always wins: it aborts waits and ends acks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!AS) begin
          if (rom_sel) begin
            state_d = (ROM_WAIT == 0) ? ACK : WAIT;
          end else if (ram_sel) begin
            state_d = (RAM_WAIT == 0) ? ACK : WAIT;
          end else begin
            state_d = PERIPH;
          end
        end
      end
      WAIT: begin
        if (AS) begin
          state_d = IDLE;
        end else if (wait_cnt <= WAIT_W'(1)) begin
          state_d = ACK;
        end
      end
      PERIPH: begin
        if (AS) begin
          state_d = IDLE;
        end else if (!ack_sync) begin
          state_d = ACK;
        end else if (to_cnt_inc >= TO_LIMIT) begin
          state_d = ERR;
        end
      end
      ACK, ERR: begin
        if (AS) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          to_cnt <= '0;
          if (rom_sel) begin
            wait_cnt <= ROM_LOAD;
          end else if (ram_sel) begin
            wait_cnt <= RAM_LOAD;
          end else begin
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        PERIPH: to_cnt <= to_cnt_inc;
        default: begin
        end
      endcase
    end
  end

  // Strobes are decoded from the next state so they change on the entry edge.
  always_comb begin
    dtack_d = (state_d != ACK);
    berr_d  = (state_d != ERR);
    BUSY    = (state_q != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DTACK <= 1'b1;
      BERR  <= 1'b1;
    end else begin
      DTACK <= dtack_d;
      BERR  <= berr_d;
    end
  end

endmodule

// File: tb/tb_mackerel_bus_timer.sv
// Randomized bench for mackerel_bus_timer: each bus cycle's response edge is
// predicted from the wait-state, synchronizer and timeout rules.
module tb_mackerel_bus_timer;

  localparam int ROM_W = 2;
  localparam int RAM_W = 0;
  localparam int TO_V  = 16;

  logic       CLK;
  logic       RST;
  logic       AS;
  logic       ROMEN;
  logic [3:0] RAMEN;
  logic       DTACK_PERIPH;
  logic       DTACK;
  logic       BERR;
  logic       BUSY;

  int errors;
  int checks;

  mackerel_bus_timer #(
    .ROM_WAIT(ROM_W),
    .RAM_WAIT(RAM_W),
    .TIMEOUT (TO_V)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .AS          (AS),
    .ROMEN       (ROMEN),
    .RAMEN       (RAMEN),
    .DTACK_PERIPH(DTACK_PERIPH),
    .DTACK       (DTACK),
    .BERR        (BERR),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One bus cycle. Inputs are driven just after edge 0; AS low is sampled at
  // edge 1. kind: 0 ROM, 1 RAM, 2 peripheral, 3 ROM+RAM both selected.
  // ack_delay: peripheral drives its ack low ack_delay edges after edge 1
  // (-1 = never). abort_at: edge after which AS rises early (-1 = none).
  task automatic run_cycle(input int kind, input int ack_delay, input int abort_at,
                           input int hold, input string tag);
    int  r;
    int  p;
    int  rel;
    int  e;
    bit  is_err;
    bit  aborted;
    bit  released;
    logic exp_dt;
    logic exp_be;
    logic exp_busy;
    is_err = 1'b0;
    p = (kind == 2 && ack_delay >= 0) ? 1 + ack_delay : -1;
    case (kind)
      0, 3: r = 1 + ROM_W;
      1:    r = 1 + RAM_W;
      default: begin
        if (p >= 0 && p + 3 <= 1 + TO_V) begin
          r = p + 3;
        end else begin
          r = 1 + TO_V;
          is_err = 1'b1;
        end
      end
    endcase
    aborted = (abort_at >= 1 && abort_at + 1 <= r);
    rel = aborted ? abort_at : r + hold;
    e = rel + 1;
    AS = 1'b0;
    ROMEN = !(kind == 0 || kind == 3);
    if (kind == 1) RAMEN = 4'($urandom_range(0, 14));
    else if (kind == 3) RAMEN = 4'b1110;
    else RAMEN = 4'hF;
    released = 1'b0;
    for (int k = 1; k <= e; k++) begin
      @(posedge CLK);
      #1;
      exp_busy = (k < e);
      exp_dt = !(!aborted && !is_err && k >= r && k < e);
      exp_be = !(!aborted && is_err && k >= r && k < e);
      checks++;
      if (DTACK !== exp_dt) begin
        errors++;
        $display("[TB] FAIL %s dtack edge %0d: got %b expected %b", tag, k, DTACK, exp_dt);
      end
      checks++;
      if (BERR !== exp_be) begin
        errors++;
        $display("[TB] FAIL %s berr edge %0d: got %b expected %b", tag, k, BERR, exp_be);
      end
      checks++;
      if (BUSY !== exp_busy) begin
        errors++;
        $display("[TB] FAIL %s busy edge %0d: got %b expected %b", tag, k, BUSY, exp_busy);
      end
      if (k == rel) begin
        AS = 1'b1;
        ROMEN = 1'b1;
        RAMEN = 4'hF;
        DTACK_PERIPH = 1'b1;
        released = 1'b1;
      end else if (k == p && !released) begin
        DTACK_PERIPH = 1'b0;
      end
    end
  endtask

  task automatic idle_edges(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (DTACK !== 1'b1 || BERR !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s idle: got dtack=%b berr=%b busy=%b expected 1 1 0",
                 tag, DTACK, BERR, BUSY);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    AS = 1'b0;
    ROMEN = 1'b0;
    RAMEN = 4'h0;
    DTACK_PERIPH = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (DTACK !== 1'b1 || BERR !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset: got dtack=%b berr=%b busy=%b expected 1 1 0",
                 DTACK, BERR, BUSY);
      end
    end
    RST = 1'b0;
    AS = 1'b1;
    ROMEN = 1'b1;
    RAMEN = 4'hF;
    DTACK_PERIPH = 1'b1;
    idle_edges(2, "post_reset");
  endtask

  task automatic test_ram_read();
    run_cycle(1, -1, -1, 0, "ram_read");
    run_cycle(1, -1, -1, 3, "ram_read_hold");
  endtask

  task automatic test_rom_read();
    run_cycle(0, -1, -1, 1, "rom_read");
  endtask

  task automatic test_periph();
    run_cycle(2, 4, -1, 1, "periph_ack");
    idle_edges(2, "periph_gap");
    run_cycle(2, 13, -1, 0, "periph_tie");
    idle_edges(2, "periph_gap");
    run_cycle(2, 14, -1, 0, "periph_late");
  endtask

  task automatic test_timeout();
    run_cycle(2, -1, -1, 2, "timeout");
  endtask

  task automatic test_abort();
    run_cycle(0, -1, 1, 0, "abort_rom_early");
    run_cycle(0, -1, 2, 0, "abort_rom_edge");
    run_cycle(2, -1, 5, 0, "abort_periph");
    idle_edges(1, "abort_gap");
  endtask

  task automatic test_priority();
    run_cycle(3, -1, -1, 1, "rom_over_ram");
  endtask

  task automatic test_back_to_back();
    run_cycle(1, -1, -1, 0, "b2b_ram");
    run_cycle(0, -1, -1, 0, "b2b_rom");
    run_cycle(2, 0, -1, 0, "b2b_periph");
    run_cycle(2, -1, -1, 0, "b2b_timeout");
    run_cycle(1, -1, -1, 0, "b2b_ram2");
  endtask

  // Reset lands in ACK, then AS is still low so a fresh ROM cycle follows.
  task automatic test_reset_mid();
    logic exp_dt;
    logic exp_busy;
    AS = 1'b0;
    ROMEN = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      exp_dt = !(k == 3 || k == 7);
      exp_busy = !(k == 4 || k == 8);
      checks++;
      if (DTACK !== exp_dt || BERR !== 1'b1 || BUSY !== exp_busy) begin
        errors++;
        $display("[TB] FAIL reset_mid edge %0d: got dtack=%b berr=%b busy=%b expected %b 1 %b",
                 k, DTACK, BERR, BUSY, exp_dt, exp_busy);
      end
      if (k == 3) RST = 1'b1;
      if (k == 4) RST = 1'b0;
      if (k == 7) begin
        AS = 1'b1;
        ROMEN = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    int kind;
    int ackd;
    int abrt;
    int hold;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      ackd = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, TO_V);
      abrt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1;
      hold = $urandom_range(0, 3);
      run_cycle(kind, ackd, abrt, hold, "random");
      if ($urandom_range(0, 1) == 1) idle_edges($urandom_range(1, 3), "random_gap");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ram_read();
    test_rom_read();
    test_periph();
    test_timeout();
    test_abort();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
